// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end for the single-port RAM: deserialises 10-bit MOSI frames
// into rx_data_o/rx_valid_o and returns the RAM read word on MISO for read-data frames.
module spi_slave_if #(
   parameter int unsigned RX_W = 10,
   parameter int unsigned TX_W = 8
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            ss_n_i,
   input  logic            mosi_i,
   output logic            miso_o,
   output logic [RX_W-1:0] rx_data_o,
   output logic            rx_valid_o,
   input  logic [TX_W-1:0] tx_data_i,
   input  logic            tx_valid_i
);

   localparam int unsigned RxCntW = $clog2(RX_W + 1);
   localparam int unsigned TxCntW = $clog2(TX_W + 1);

   typedef enum logic [2:0] {StIdle, StChkCmd, StWrite, StReadAdd, StReadData} state_e;

   state_e              state_q, state_d;
   logic [RX_W-1:0]     rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                miso_q, miso_d;
   logic                rd_addr_seen_q, rd_addr_seen_d;
   logic [RxCntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic                frame_done_q, frame_done_d;
   logic [TX_W-1:0]     tx_sh_q, tx_sh_d;
   logic [TxCntW-1:0]   tx_left_q, tx_left_d;
   logic                tx_got_q, tx_got_d;
   logic                in_frame;

   assign in_frame = (state_q == StWrite) || (state_q == StReadAdd) || (state_q == StReadData);

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q        <= StIdle;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         miso_q         <= 1'b0;
         rd_addr_seen_q <= 1'b0;
         bit_cnt_q      <= '0;
         frame_done_q   <= 1'b0;
         tx_sh_q        <= '0;
         tx_left_q      <= '0;
         tx_got_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         miso_q         <= miso_d;
         rd_addr_seen_q <= rd_addr_seen_d;
         bit_cnt_q      <= bit_cnt_d;
         frame_done_q   <= frame_done_d;
         tx_sh_q        <= tx_sh_d;
         tx_left_q      <= tx_left_d;
         tx_got_q       <= tx_got_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q != StIdle && ss_n_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:   if (!ss_n_i) state_d = StChkCmd;
            StChkCmd: begin
               if (!mosi_i)             state_d = StWrite;
               else if (rd_addr_seen_q) state_d = StReadData;
               else                     state_d = StReadAdd;
            end
            default:  state_d = state_q;
         endcase
      end
   end

   // Datapath next-state; miso defaults low and is only raised while shifting the reply.
   always_comb begin
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      miso_d         = 1'b0;
      rd_addr_seen_d = rd_addr_seen_q;
      bit_cnt_d      = bit_cnt_q;
      frame_done_d   = frame_done_q;
      tx_sh_d        = tx_sh_q;
      tx_left_d      = tx_left_q;
      tx_got_d       = tx_got_q;
      if (state_q == StIdle || ss_n_i) begin
         bit_cnt_d    = '0;
         frame_done_d = 1'b0;
         tx_left_d    = '0;
         tx_got_d     = 1'b0;
      end else if (state_q == StChkCmd) begin
         rx_data_d = {rx_data_q[RX_W-2:0], mosi_i};
         bit_cnt_d = RxCntW'(1);
      end else if (in_frame) begin
         if (!frame_done_q) begin
            rx_data_d = {rx_data_q[RX_W-2:0], mosi_i};
            bit_cnt_d = bit_cnt_q + RxCntW'(1);
            if (bit_cnt_q == RxCntW'(RX_W - 1)) begin
               frame_done_d = 1'b1;
               rx_valid_d   = 1'b1;
               if (state_q == StReadAdd)  rd_addr_seen_d = 1'b1;
               if (state_q == StReadData) rd_addr_seen_d = 1'b0;
            end
         end else if (state_q == StReadData && !tx_got_q && tx_valid_i) begin
            tx_sh_d   = tx_data_i;
            tx_left_d = TxCntW'(TX_W);
            tx_got_d  = 1'b1;
         end else if (tx_left_q != '0) begin
            miso_d    = tx_sh_q[TX_W-1];
            tx_sh_d   = {tx_sh_q[TX_W-2:0], 1'b0};
            tx_left_d = tx_left_q - TxCntW'(1);
         end
      end
   end

   always_comb begin
      miso_o     = miso_q;
      rx_data_o  = rx_data_q;
      rx_valid_o = rx_valid_q;
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frame decode, read-address flag, MISO reply, abort, reset.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       ss_n;
   logic       mosi;
   logic       miso;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   spi_slave_if #(.RX_W(10), .TX_W(8)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .ss_n_i     (ss_n),
      .mosi_i     (mosi),
      .miso_o     (miso),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid)
   );

   // Drives nbits of f MSB first; a short frame is aborted by raising ss_n right after.
   task automatic shift_frame(input logic [9:0] f, input int nbits, output int pulses,
                              output int first_at, output logic [9:0] data);
      pulses = 0; first_at = -1; data = '0;
      @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         if (rx_valid) begin pulses++; if (first_at < 0) first_at = i; data = rx_data; end
         mosi = f[9-i];
      end
      if (nbits < 10) begin
         @(negedge clk);
         if (rx_valid) begin pulses++; if (first_at < 0) first_at = nbits; end
         ss_n = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rx_valid) begin
            pulses++; if (first_at < 0) first_at = 10 + k; data = rx_data;
         end
      end
   endtask

   task automatic end_frame();
      @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Pulses tx_valid, then collects the 8 MISO bits plus the level before and after.
   task automatic read_reply(input logic [7:0] d, output logic lead, output logic [7:0] got,
                             output logic trail);
      @(negedge clk); tx_valid = 1'b1; tx_data = d;
      @(negedge clk); tx_valid = 1'b0; tx_data = 8'h00; lead = miso;
      got = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); got = {got[6:0], miso};
      end
      @(negedge clk); trail = miso;
   endtask

   task automatic test_reset();
      arst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({rx_valid, miso, rx_data} !== 12'h000) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 000", {rx_valid, miso, rx_data});
      end
      arst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_addr();
      int p, at; logic [9:0] d;
      shift_frame(10'h0A5, 10, p, at, d);
      n_cmp++;
      if (p !== 1 || at !== 10) begin
         n_bad++; $display("FAIL wr_addr_pulse: got %0d@%0d want 1@10", p, at);
      end
      n_cmp++;
      if (d !== 10'h0A5) begin n_bad++; $display("FAIL wr_addr_data: got %h want 0a5", d); end
      end_frame();
   endtask

   task automatic test_write_data();
      int p, at; logic [9:0] d;
      shift_frame(10'h13C, 10, p, at, d);
      n_cmp++;
      if (p !== 1 || d !== 10'h13C) begin
         n_bad++; $display("FAIL wr_data: got %0d/%h want 1/13c", p, d);
      end
      end_frame();
      n_cmp++;
      if (rx_data !== 10'h13C) begin
         n_bad++; $display("FAIL rx_data_hold: got %h want 13c", rx_data);
      end
   endtask

   // Writes must not set the flag, so this read frame is a read-address frame (no reply).
   task automatic test_read_addr();
      int p, at; logic [9:0] d; logic ld, tr; logic [7:0] g;
      shift_frame(10'h2A5, 10, p, at, d);
      n_cmp++;
      if (p !== 1 || d !== 10'h2A5) begin
         n_bad++; $display("FAIL rd_addr: got %0d/%h want 1/2a5", p, d);
      end
      read_reply(8'hA5, ld, g, tr);
      n_cmp++;
      if ({ld, g, tr} !== 10'h000) begin
         n_bad++; $display("FAIL rd_addr_no_miso: got %h want 000", {ld, g, tr});
      end
      end_frame();
   endtask

   task automatic test_read_data();
      int p, at; logic [9:0] d; logic ld, tr; logic [7:0] g;
      shift_frame(10'h300, 10, p, at, d);
      n_cmp++;
      if (p !== 1 || d !== 10'h300) begin
         n_bad++; $display("FAIL rd_data_frame: got %0d/%h want 1/300", p, d);
      end
      read_reply(8'h3C, ld, g, tr);
      n_cmp++;
      if (ld !== 1'b0 || g !== 8'h3C || tr !== 1'b0) begin
         n_bad++; $display("FAIL rd_data_miso: got %b/%h/%b want 0/3c/0", ld, g, tr);
      end
      end_frame();
   endtask

   // Flag was cleared by the read-data frame: next read frame is read-address again.
   task automatic test_flag_clear();
      int p, at; logic [9:0] d; logic ld, tr; logic [7:0] g;
      shift_frame(10'h3FF, 10, p, at, d);
      read_reply(8'hFF, ld, g, tr);
      n_cmp++;
      if ({ld, g, tr} !== 10'h000) begin
         n_bad++; $display("FAIL flag_clear: got %h want 000", {ld, g, tr});
      end
      end_frame();
   endtask

   // Flag is now set; an aborted read frame must leave it set.
   task automatic test_abort();
      int p, at; logic [9:0] d; logic ld, tr; logic [7:0] g;
      shift_frame(10'h3FF, 5, p, at, d);
      n_cmp++;
      if (p !== 0) begin n_bad++; $display("FAIL abort_no_pulse: got %0d want 0", p); end
      end_frame();
      shift_frame(10'h381, 10, p, at, d);
      n_cmp++;
      if (p !== 1 || d !== 10'h381) begin
         n_bad++; $display("FAIL abort_next_frame: got %0d/%h want 1/381", p, d);
      end
      read_reply(8'h96, ld, g, tr);
      n_cmp++;
      if (g !== 8'h96) begin n_bad++; $display("FAIL abort_flag_kept: got %h want 96", g); end
      end_frame();
   endtask

   task automatic test_abort_miso();
      int p, at; logic [9:0] d; logic ok;
      shift_frame(10'h2C3, 10, p, at, d);
      end_frame();
      shift_frame(10'h3C3, 10, p, at, d);
      @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
      @(negedge clk); tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (miso !== 1'b1) begin n_bad++; $display("FAIL miso_shifting: got %b want 1", miso); end
      ss_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (miso !== 1'b0) ok = 1'b0; end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL miso_drop: got 1 want 0"); end
   endtask

   // Extra clocks after a complete frame are ignored, including a stray tx_valid.
   task automatic test_back_to_back();
      int p, at, extra; logic [9:0] d; logic high;
      shift_frame(10'h155, 10, p, at, d);
      extra = 0; high = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rx_valid) extra++;
         if (miso) high = 1'b1;
         mosi = i[0]; tx_valid = (i == 4); tx_data = 8'hFF;
      end
      tx_valid = 1'b0;
      n_cmp++;
      if (p !== 1 || extra !== 0 || high !== 1'b0) begin
         n_bad++; $display("FAIL frame_reuse: got %0d/%0d/%b want 1/0/0", p, extra, high);
      end
      n_cmp++;
      if (rx_data !== 10'h155) begin
         n_bad++; $display("FAIL reuse_hold: got %h want 155", rx_data);
      end
      end_frame();
   endtask

   task automatic test_reset_mid();
      int p, at; logic [9:0] d; logic ld, tr; logic [7:0] g;
      shift_frame(10'h2AA, 10, p, at, d);
      end_frame();
      shift_frame(10'h3AA, 10, p, at, d);
      @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
      @(negedge clk); tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      arst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({miso, rx_valid, rx_data} !== 12'h000) begin
         n_bad++; $display("FAIL reset_mid_shift: got %h want 000", {miso, rx_valid, rx_data});
      end
      arst_n = 1'b1; ss_n = 1'b1;
      @(negedge clk);
      // Set the flag, then reset mid-frame: it must come back clear.
      shift_frame(10'h2AA, 10, p, at, d);
      end_frame();
      @(negedge clk); ss_n = 1'b0; mosi = 1'b1;
      repeat (3) @(negedge clk);
      arst_n = 1'b0;
      @(negedge clk); arst_n = 1'b1; ss_n = 1'b1;
      @(negedge clk);
      shift_frame(10'h3AA, 10, p, at, d);
      n_cmp++;
      if (p !== 1 || d !== 10'h3AA) begin
         n_bad++; $display("FAIL post_reset_frame: got %0d/%h want 1/3aa", p, d);
      end
      read_reply(8'hFF, ld, g, tr);
      n_cmp++;
      if ({ld, g, tr} !== 10'h000) begin
         n_bad++; $display("FAIL reset_clears_flag: got %h want 000", {ld, g, tr});
      end
      end_frame();
   endtask

   initial begin
      test_reset();
      test_write_addr();
      test_write_data();
      test_read_addr();
      test_read_data();
      test_flag_clear();
      test_abort();
      test_abort_miso();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
